// File: rtl/frame_pkg.sv
// Shared types and constants for the frame byte-to-word packer.
package frame_pkg;

    localparam int WORD_W              = 32;
    localparam int BYTE_W              = 8;
    localparam int DEF_MAX_FRAME_BYTES = 1518;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        CLEAR
    } state_t;

    // Byte position inside a word; lane 0 sits in [31:24].
    typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/frame_word_packer_if.sv
// Byte-stream input and word-stream output of the frame packer.
// master: the environment (byte source and word sink); slave: the packer.
interface frame_word_packer_if #(
    parameter int LEN_W = 11
);
    import frame_pkg::*;

    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              sof;
    logic              eof;
    logic              byte_ready;
    logic [WORD_W-1:0] data_out;
    logic              word_valid;
    logic              word_last;
    logic [1:0]        last_bytes;
    logic [LEN_W-1:0]  frame_len;
    logic              clear;
    logic              abort;

    modport master (
        output byte_in, byte_valid, sof, eof,
        input  byte_ready, data_out, word_valid, word_last, last_bytes,
               frame_len, clear, abort
    );

    modport slave (
        input  byte_in, byte_valid, sof, eof,
        output byte_ready, data_out, word_valid, word_last, last_bytes,
               frame_len, clear, abort
    );

endinterface

// File: rtl/pack_shift_reg.sv
// Four-lane byte register that assembles one big-endian word.
// word_o is the word as it will look with this cycle's write applied, so the
// owner can capture a completed word in the same cycle its last byte lands.
module pack_shift_reg
    import frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              restart_i,
    input  logic              flush_i,
    input  lane_idx_t         lane_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o
);

    logic [3:0][BYTE_W-1:0] lanes_q;
    logic [3:0][BYTE_W-1:0] lanes_d;
    lane_idx_t              lane_eff;
    lane_idx_t              pos;

    // Merge the incoming byte; a restart drops old lanes and writes lane 0.
    always_comb begin
        lanes_d  = lanes_q;
        lane_eff = restart_i ? 2'd0 : lane_i;
        pos      = 2'd3 - lane_eff;
        if (restart_i) begin
            lanes_d = '0;
        end
        if (wr_en_i) begin
            lanes_d[pos] = byte_i;
        end
    end

    assign word_o = lanes_d;

    // Hold the partial word; flushing zeroes the lanes so the next word pads with 0.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: lanes are reset too, so an unfilled lane is always 0 even for the
        // first frame after reset; registers use non-blocking assignments only.
        if (rst) begin
            lanes_q <= '0;
        end else if (flush_i) begin
            lanes_q <= '0;
        end else if (wr_en_i) begin
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/frame_word_packer.sv
// Packs a sof/eof-delimited byte stream into 32-bit big-endian words, reports
// frame length and last-word byte count, and pulses clear/abort for matchers.
// Optional: FRAME_WORD_PACKER_OVERSIZE_EN truncates frames at MAX_FRAME_BYTES
// and adds an oversize pulse alongside word_last.
module frame_word_packer
    import frame_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = DEF_MAX_FRAME_BYTES,
    parameter int LEN_W           = $clog2(MAX_FRAME_BYTES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    frame_word_packer_if.slave bus
`ifdef FRAME_WORD_PACKER_OVERSIZE_EN
    ,
    output logic              oversize
`endif
);

    state_t            state_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  cnt_d;
    logic [LEN_W-1:0]  cnt_inc;
    logic              byte_ready_q;
    logic              word_valid_q;
    logic              word_last_q;
    logic [1:0]        last_bytes_q;
    logic [LEN_W-1:0]  frame_len_q;
    logic [WORD_W-1:0] data_out_q;
    logic              clear_q;
    logic              abort_q;

    logic              accept;
    logic              sr_wr;
    logic              sr_restart;
    logic              sr_flush;
    logic              drop_byte;
    logic              hold_full;
    logic              end_frame;
    logic [WORD_W-1:0] sr_word;
    lane_idx_t         lane;

`ifdef FRAME_WORD_PACKER_OVERSIZE_EN
    logic              drop_q;
    logic              oversize_q;
`endif

    assign accept    = bus.byte_valid & byte_ready_q;
    assign lane      = cnt_q[1:0];
    assign cnt_inc   = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    // Every flush emits a word; only an eof-driven flush ends the frame.
    assign end_frame = sr_flush & bus.eof;

    pack_shift_reg u_pack (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (sr_wr),
        .restart_i (sr_restart),
        .flush_i   (sr_flush),
        .lane_i    (lane),
        .byte_i    (bus.byte_in),
        .word_o    (sr_word)
    );

    // Decide what the accepted byte does to the lanes and the length counter.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        sr_wr      = 1'b0;
        sr_restart = 1'b0;
        sr_flush   = 1'b0;
        drop_byte  = 1'b0;
        hold_full  = 1'b0;
        cnt_d      = cnt_q;
        if (accept && (state_q == IDLE || state_q == PACK)) begin
            if (bus.sof) begin
                sr_wr      = 1'b1;
                sr_restart = 1'b1;
                sr_flush   = bus.eof;
                cnt_d      = LEN_W'(1);
            end else if (state_q == PACK) begin
`ifdef FRAME_WORD_PACKER_OVERSIZE_EN
                drop_byte = drop_q || (cnt_q >= LEN_W'(MAX_FRAME_BYTES));
                // A word completed by the byte that reaches the limit may turn out
                // to be the frame's last word, so it waits for eof.
                hold_full = (cnt_inc == LEN_W'(MAX_FRAME_BYTES));
`endif
                if (drop_byte) begin
                    sr_flush = bus.eof;
                end else begin
                    sr_wr    = 1'b1;
                    cnt_d    = cnt_inc;
                    sr_flush = bus.eof || (lane == 2'd3 && !hold_full);
                end
            end
        end
    end

    // FSM, length counter and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            byte_ready_q <= 1'b1;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            last_bytes_q <= 2'd0;
            frame_len_q  <= '0;
            data_out_q   <= '0;
            clear_q      <= 1'b0;
            abort_q      <= 1'b0;
`ifdef FRAME_WORD_PACKER_OVERSIZE_EN
            drop_q       <= 1'b0;
            oversize_q   <= 1'b0;
`endif
        end else begin
            word_valid_q <= sr_flush;
            word_last_q  <= end_frame;
            clear_q      <= 1'b0;
            abort_q      <= 1'b0;
            cnt_q        <= cnt_d;
            if (sr_flush) begin
                data_out_q <= sr_word;
            end
            if (end_frame) begin
                last_bytes_q <= cnt_d[1:0];
                frame_len_q  <= cnt_d;
            end
`ifdef FRAME_WORD_PACKER_OVERSIZE_EN
            oversize_q <= end_frame & drop_byte;
            if (accept && bus.sof) begin
                drop_q <= 1'b0;
            end else if (drop_byte) begin
                drop_q <= 1'b1;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (accept && bus.sof) begin
                        state_q <= bus.eof ? CLEAR : PACK;
                    end
                end
                PACK: begin
                    if (accept) begin
                        if (bus.sof) begin
                            abort_q <= 1'b1;
                            clear_q <= 1'b1;
                        end
                        if (bus.eof) begin
                            state_q <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    clear_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // Input stays closed through the last-word and clear cycles.
            byte_ready_q <= !(end_frame || state_q == CLEAR);
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.data_out   = data_out_q;
    assign bus.word_valid = word_valid_q;
    assign bus.word_last  = word_last_q;
    assign bus.last_bytes = last_bytes_q;
    assign bus.frame_len  = frame_len_q;
    assign bus.clear      = clear_q;
    assign bus.abort      = abort_q;
`ifdef FRAME_WORD_PACKER_OVERSIZE_EN
    assign oversize       = oversize_q;
`endif

endmodule

// File: tb/tb_frame_word_packer.sv
// Scoreboard bench for frame_word_packer: the driver pushes expected words and
// clear/abort events computed from whole frames; a negedge monitor pops them.
module tb_frame_word_packer;
    import frame_pkg::*;

`ifdef FRAME_WORD_PACKER_OVERSIZE_EN
    localparam int MAXB = 8;
`else
    localparam int MAXB = DEF_MAX_FRAME_BYTES;
`endif
    localparam int LEN_W = $clog2(MAXB + 1);

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  lb;
        int          flen;
        logic        ovs;
        int          due;
    } word_exp_t;

    typedef struct {
        logic abort;
        int   due;
    } clr_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_word_packer_if #(.LEN_W(LEN_W)) bus ();
`ifdef FRAME_WORD_PACKER_OVERSIZE_EN
    logic oversize;
`endif

    frame_word_packer #(.MAX_FRAME_BYTES(MAXB), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FRAME_WORD_PACKER_OVERSIZE_EN
        ,
        .oversize (oversize)
`endif
    );

    word_exp_t wq[$];
    clr_exp_t  cq[$];
    int        checks     = 0;
    int        failures   = 0;
    int        cyc        = 0;
    bit        frame_open = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    word_exp_t e;
    clr_exp_t  c;
    logic      prev_last;
    logic      prev_end_clear;

    always @(negedge clk) begin
        if (rst) begin
            prev_last      = 1'b0;
            prev_end_clear = 1'b0;
        end else begin
            if (prev_end_clear) check("ready_after_clear", bus.byte_ready, 1);
            if (prev_last) check("clear_after_last", bus.clear, 1);
            if (bus.word_valid) begin
                if (wq.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    e = wq.pop_front();
                    check("word_data", bus.data_out, e.data);
                    check("word_last", bus.word_last, e.last);
                    check("word_cycle", cyc, e.due);
                    if (e.last) begin
                        check("last_bytes", bus.last_bytes, e.lb);
                        check("frame_len", bus.frame_len, e.flen);
`ifdef FRAME_WORD_PACKER_OVERSIZE_EN
                        check("oversize", oversize, e.ovs);
`endif
                    end
                end
            end
            if (bus.clear || bus.abort) begin
                if (cq.size() == 0) begin
                    check("unexpected_clear", 1, 0);
                end else begin
                    c = cq.pop_front();
                    check("clear_pulse", bus.clear, 1);
                    check("abort_pulse", bus.abort, c.abort);
                    check("clear_cycle", cyc, c.due);
                    if (!c.abort) check("ready_in_clear", bus.byte_ready, 0);
                end
            end
            prev_last      = bus.word_valid && bus.word_last;
            prev_end_clear = bus.clear && !bus.abort;
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic byte_q_t str_bytes(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Word w of a frame whose first `kept` bytes are packed, zero padded.
    function automatic logic [31:0] word_of(input byte_q_t d, input int w, input int kept);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            if (4 * w + j < kept) r[31 - 8 * j -: 8] = d[4 * w + j];
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic idle_cycles(input int n);
        bus.byte_valid = 1'b0;
        bus.sof        = 1'b0;
        bus.eof        = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one byte until accepted; returns the cycle it was accepted in.
    task automatic put_byte(input logic [7:0] b, input logic s, input logic f, output int acc);
        int waited;
        waited         = 0;
        acc            = -1;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        bus.sof        = s;
        bus.eof        = f;
        while (acc < 0 && waited < 10) begin
            @(negedge clk);
            if (bus.byte_ready === 1'b1) acc = cyc;
            @(posedge clk);
            #1;
            waited++;
        end
        if (acc < 0) check("byte_accept_timeout", 0, 1);
        bus.byte_valid = 1'b0;
        bus.sof        = 1'b0;
        bus.eof        = 1'b0;
    endtask

    task automatic send_frame(input byte_q_t d, input bit finish, input int gap_pct);
        int n;
        int kept;
        int nw;
        int acc;
        n = d.size();
`ifdef FRAME_WORD_PACKER_OVERSIZE_EN
        kept = (n > MAXB) ? MAXB : n;
`else
        kept = n;
`endif
        nw = (kept + 3) / 4;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gap_pct > 0 && $urandom_range(99) < gap_pct)
                idle_cycles($urandom_range(1, 3));
            put_byte(d[i], i == 0, finish && i == n - 1, acc);
            if (i == 0) begin
                if (frame_open) cq.push_back('{abort: 1'b1, due: acc + 1});
                frame_open = 1;
            end
            if (i % 4 == 3 && i / 4 < nw - 1)
                wq.push_back('{data: word_of(d, i / 4, kept), last: 1'b0, lb: 2'd0,
                               flen: 0, ovs: 1'b0, due: acc + 1});
            if (finish && i == n - 1) begin
                wq.push_back('{data: word_of(d, nw - 1, kept), last: 1'b1,
                               lb: 2'(kept % 4), flen: kept, ovs: (n > kept),
                               due: acc + 1});
                cq.push_back('{abort: 1'b0, due: acc + 2});
                frame_open = 0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, bus.data_out, 0);
        check({tag, "_word_valid"}, bus.word_valid, 0);
        check({tag, "_word_last"}, bus.word_last, 0);
        check({tag, "_last_bytes"}, bus.last_bytes, 0);
        check({tag, "_frame_len"}, bus.frame_len, 0);
        check({tag, "_clear"}, bus.clear, 0);
        check({tag, "_abort"}, bus.abort, 0);
        check({tag, "_byte_ready"}, bus.byte_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        byte_q_t d;
        int      acc;
        int      len;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        bus.sof        = 1'b0;
        bus.eof        = 1'b0;
        rst            = 1'b1;
        #12;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        // Directed frames.
        send_frame(str_bytes("www.purd"), 1, 0);
        idle_cycles(3);
        send_frame(str_bytes("www.purdue.edu"), 1, 40);
        idle_cycles(2);
        d = {8'hAB};
        send_frame(d, 1, 0);
        idle_cycles(2);

        // Abort: sof plus two bytes, then a fresh sof with 8'h11.
        d = {8'hA0, 8'hA1, 8'hA2};
        send_frame(d, 0, 0);
        d = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(d, 1, 0);

        // Bytes outside a frame are dropped, including a lone eof.
        put_byte(8'h99, 1'b0, 1'b0, acc);
        put_byte(8'h98, 1'b0, 1'b1, acc);
        idle_cycles(2);

`ifdef FRAME_WORD_PACKER_OVERSIZE_EN
        send_frame(str_bytes("ABCDEFGHIJKL"), 1, 0);
        idle_cycles(2);
        send_frame(str_bytes("abcdefghi"), 1, 20);
        idle_cycles(2);
`endif

        // Randomized frames, stalls, stray bytes and aborts.
        for (int k = 0; k < 50; k++) begin
            if (!frame_open && $urandom_range(3) == 0)
                put_byte(8'($urandom), 1'b0, 1'($urandom_range(1)), acc);
            d.delete();
            if ($urandom_range(99) < 15) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) d.push_back(8'($urandom));
                send_frame(d, 0, 30);
            end else begin
                len = $urandom_range(1, 20);
                for (int i = 0; i < len; i++) d.push_back(8'($urandom));
                send_frame(d, 1, 30);
            end
            if ($urandom_range(1) == 1) idle_cycles($urandom_range(1, 4));
        end
        if (frame_open) send_frame(str_bytes("end!"), 1, 0);
        idle_cycles(4);

        // Reset in the middle of a partially packed frame.
        d = {8'hC1, 8'hC2, 8'hC3};
        send_frame(d, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        frame_open = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(1);
        send_frame(str_bytes("ok!"), 1, 0);

        for (int t = 0; t < 20 && (wq.size() != 0 || cq.size() != 0); t++) @(posedge clk);
        #1;
        check("queues_drained", 64'(wq.size() + cq.size()), 0);
        idle_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_word_packer.md
Name: frame_word_packer

Overview:
- Converts the receive-side byte stream (one byte per cycle, with sof/eof markers) into the 32-bit big-endian word stream consumed by string_comparator2 and the other word-level matchers.
- It is the writer for the comparator's data_in/clear interface. It packs bytes into words, pads the final partial word, reports frame length and valid-byte count, and issues the one-cycle clear that resets matcher state between frames.

Parameters:
- MAX_FRAME_BYTES, 1518, largest legal frame length in bytes.
- LEN_W, $clog2(MAX_FRAME_BYTES+1), width of the frame length counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- byte_in  in  8  receive byte.
- byte_valid  in  1  byte_in is valid this cycle.
- sof  in  1  qualifies byte_in as the first byte of a frame (valid only with byte_valid).
- eof  in  1  qualifies byte_in as the last byte of a frame (valid only with byte_valid).
- byte_ready  out  1  packer accepts a byte this cycle; a byte is accepted only when byte_valid & byte_ready.
- data_out  out  32  packed word; first byte of the word in [31:24].
- word_valid  out  1  data_out holds a new word (one-cycle pulse per word).
- word_last  out  1  with word_valid: final word of the frame.
- last_bytes  out  2  with word_last: valid bytes in the final word; 0 encodes 4.
- frame_len  out  LEN_W  byte count of the frame; valid and held from the word_last cycle until the next sof.
- clear  out  1  one-cycle pulse to downstream matchers after every frame end or abort.
- abort  out  1  one-cycle pulse when a frame is abandoned mid-frame.

Behaviour:
- Reset (async, rst=1): state IDLE. data_out=0, word_valid=0, word_last=0, last_bytes=0, frame_len=0, clear=0, abort=0. byte_ready=1.
- States: IDLE, PACK, CLEAR.
- IDLE:
  - An accepted byte without sof is dropped: no count, no output.
  - An accepted byte with sof loads lane 0 ([31:24]) and sets the length counter to 1.
  - If eof is also set, the frame ends immediately. Otherwise go to PACK.
- PACK:
  - Each accepted byte fills the next lane (lane index = count mod 4) and increments the length counter.
  - When lane 3 fills at cycle N: data_out = packed word and word_valid=1 at cycle N+1, with the pipeline latency fixed at 1. Lanes are cleared to 0 for the next word.
- Frame end (accepted byte with eof at cycle N):
  - Cycle N+1: word_valid=1 and word_last=1. Unfilled lanes are 0. last_bytes = count mod 4. frame_len = count.
  - Go to CLEAR.
- CLEAR:
  - Lasts exactly one cycle (N+2): clear=1, byte_ready=0, and any byte on the bus is ignored.
  - Next state is IDLE. byte_ready returns to 1 at N+3.
- sof while in PACK (the abort case):
  - The partial word is discarded and no word is emitted for it.
  - abort=1 and clear=1 in the next cycle.
  - The sof byte starts a new frame in lane 0 with count=1, and the state stays PACK. No CLEAR-state bubble occurs on abort.
- byte_valid=0 cycles inside a frame stall packing; no state changes.
- eof without sof in IDLE: dropped.
- Length counter saturates at 2^LEN_W-1 and never wraps.
- word_valid, word_last, clear and abort are single-cycle pulses. data_out holds its last value between pulses.
- rst asserted mid-frame: all state returns to the reset values immediately. The partial frame is lost and no clear pulse is issued.

Optional Feature:
- Macro: FRAME_WORD_PACKER_OVERSIZE_EN.
- Defined:
  - The byte that would make the count exceed MAX_FRAME_BYTES is dropped, and all further bytes until eof are dropped.
  - At eof the normal last-word and clear sequence runs with frame_len=MAX_FRAME_BYTES. An extra output port oversize (1 bit) pulses together with word_last.
- Undefined: no oversize port and no truncation. Bytes are packed up to the counter saturation limit.

Decomposition:
- Package frame_pkg holds:
  - the state enum typedef (IDLE, PACK, CLEAR);
  - WORD_W=32 and BYTE_W=8;
  - the lane-index typedef logic [1:0];
  - the MAX_FRAME_BYTES default.
- Sub-module pack_shift_reg contains the 4-lane byte register with lane write-enable, clear, and packed-word output. It is instantiated once. The FSM, counter and output pulses stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle with the frame partially packed -> all outputs 0 asynchronously; byte_ready=1.
- 8-byte frame "www.purd":
  - sof with 'w' and eof with 'd' -> words 32'h7777772E then 32'h70757264;
  - second word has word_last=1, last_bytes=0, frame_len=8;
  - clear pulses exactly one cycle after word_last; byte_ready=0 in that cycle.
- 14-byte frame "www.purdue.edu" with byte_valid gaps inserted:
  - words 7777772E, 70757264, 75652E65, 64750000;
  - last word has last_bytes=2, frame_len=14, and each word_valid arrives one cycle after its 4th byte.
- Single-byte frame (sof=eof=1, byte 8'hAB) -> data_out=32'hAB000000, word_last=1, last_bytes=1, frame_len=1, then clear.
- Abort: sof, then 2 bytes, then a new sof with 8'h11 -> abort=1 and clear=1 for one cycle; no word emitted for the old frame; the new frame's first word begins 8'h11.
- FRAME_WORD_PACKER_OVERSIZE_EN with MAX_FRAME_BYTES=8 and a 12-byte frame -> two words emitted; the last has word_last=1, frame_len=8 and oversize=1, followed by clear.
